// File: rtl/rom_reader_pkg.sv
// ----------------------------------------------------------------------------
// rom_reader_pkg
//   Shared constants for the lab ROM read master: default bus widths (also
//   used by the ROM and the bench), the latency counter width and the FSM
//   state encoding.
//   Optional feature macro: ROM_READER_CHECKSUM_EN (see rom_reader.sv).
// ----------------------------------------------------------------------------
package rom_reader_pkg;

   localparam int DEF_ADDR_W  = 2;
   localparam int DEF_DATA_W  = 4;
   localparam int DEF_ROM_LAT = 1;

   // Wide enough to count up to the largest legal ROM latency (3).
   localparam int LAT_W = 2;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT    = 3'd1,
      CAPTURE = 3'd2,
      HOLD    = 3'd3,
      DONE    = 3'd4
   } state_t;

endpackage

// File: rtl/rom_reader_if.sv
// ----------------------------------------------------------------------------
// rom_reader_if
//   Bundles the ROM side, the consumer handshake and the pass control of the
//   ROM read master.
//   Signals:
//     start       pass request (controller -> reader)
//     rom_addr    address to the synchronous ROM (reader -> ROM)
//     rom_data    ROM read data (ROM -> reader)
//     word_out    captured word, stable while word_valid=1
//     word_valid  word_out holds a word not yet accepted
//     word_ready  consumer accepts on word_valid && word_ready at CLK rise
//     busy        pass in progress
//     done        one-clock end-of-pass pulse
//     checksum    XOR of all words of the last pass
//                 (only with ROM_READER_CHECKSUM_EN defined)
//   Modports: master = the reader, slave = ROM/consumer/controller side.
// ----------------------------------------------------------------------------
interface rom_reader_if
   import rom_reader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);

   logic              start;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] word_out;
   logic              word_valid;
   logic              word_ready;
   logic              busy;
   logic              done;
`ifdef ROM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   modport master (
      input  start, rom_data, word_ready,
`ifdef ROM_READER_CHECKSUM_EN
      output checksum,
`endif
      output rom_addr, word_out, word_valid, busy, done
   );

   modport slave (
      output start, rom_data, word_ready,
`ifdef ROM_READER_CHECKSUM_EN
      input  checksum,
`endif
      input  rom_addr, word_out, word_valid, busy, done
   );

endinterface

// File: rtl/rom_reader.sv
// ----------------------------------------------------------------------------
// rom_reader
//   Sequential read master for the synchronous lab ROM. A start pulse in IDLE
//   walks every address 0..2**ADDR_W-1 once; each returned word is offered to
//   the consumer on a valid/ready handshake, then done pulses for one clock.
//
//   Parameters:
//     ADDR_W   ROM address width (depth = 2**ADDR_W)
//     DATA_W   ROM word width
//     ROM_LAT  clocks from the ROM sampling rom_addr to rom_data valid, 1..3
//
//   Ports:
//     CLK   system clock, rising edge
//     RST   synchronous, active-high reset (wins over start)
//     bus   rom_reader_if.master (start, ROM bus, word handshake, busy, done)
//
//   Optional feature macro ROM_READER_CHECKSUM_EN: adds bus.checksum, the XOR
//   of all words accepted in the current/last pass, cleared on start and RST.
// ----------------------------------------------------------------------------
module rom_reader
   import rom_reader_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ROM_LAT = DEF_ROM_LAT
) (
   input  logic         CLK,
   input  logic         RST,
   rom_reader_if.master bus
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   // WAIT lasts ROM_LAT clocks: leaving on this value means the counter
   // reaches ROM_LAT on the same edge that enters CAPTURE.
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ROM_LAT - 1);

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [DATA_W-1:0] word_q, word_d;
`ifdef ROM_READER_CHECKSUM_EN
   logic [DATA_W-1:0] chk_q, chk_d;
`endif

   // ---------------------------------------------------------------------
   // Next-state and next-register values
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets its hold value first, so no path through the
      // case below can leave one unassigned and infer a latch.
      state_nxt = state;
      addr_d    = addr_q;
      lat_d     = lat_q;
      word_d    = word_q;
`ifdef ROM_READER_CHECKSUM_EN
      chk_d     = chk_q;
`endif

      case (state)
         IDLE: begin
            if (bus.start) begin
               addr_d    = '0;
               lat_d     = '0;
`ifdef ROM_READER_CHECKSUM_EN
               chk_d     = '0;
`endif
               state_nxt = WAIT;
            end
         end

         // The address was set on entry; the ROM samples it on the first
         // WAIT edge and the data is valid ROM_LAT edges after that.
         WAIT: begin
            lat_d = lat_q + 1'b1;
            if (lat_q == LAT_LAST) begin
               state_nxt = CAPTURE;
            end
         end

         CAPTURE: begin
            word_d    = bus.rom_data;
            state_nxt = HOLD;
         end

         // Back-pressure simply parks here: address and word are untouched.
         HOLD: begin
            if (bus.word_ready) begin
`ifdef ROM_READER_CHECKSUM_EN
               chk_d = chk_q ^ word_q;
`endif
               if (addr_q == ADDR_LAST) begin
                  state_nxt = DONE;
               end else begin
                  addr_d    = addr_q + 1'b1;
                  lat_d     = '0;
                  state_nxt = WAIT;
               end
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values; reset is synchronous and overrides start.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         addr_q <= '0;
         lat_q  <= '0;
         word_q <= '0;
`ifdef ROM_READER_CHECKSUM_EN
         chk_q  <= '0;
`endif
      end else begin
         state  <= state_nxt;
         addr_q <= addr_d;
         lat_q  <= lat_d;
         word_q <= word_d;
`ifdef ROM_READER_CHECKSUM_EN
         chk_q  <= chk_d;
`endif
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: status flags are pure decodes of the registered state, so
   // they change exactly on the edges that move the FSM.
   // ---------------------------------------------------------------------
   assign bus.rom_addr   = addr_q;
   assign bus.word_out   = word_q;
   assign bus.word_valid = (state == HOLD);
   assign bus.busy       = (state == WAIT) || (state == CAPTURE) || (state == HOLD);
   assign bus.done       = (state == DONE);
`ifdef ROM_READER_CHECKSUM_EN
   assign bus.checksum   = chk_q;
`endif

endmodule

// File: tb/tb_rom_reader.sv
// ----------------------------------------------------------------------------
// tb_rom_reader
//   Two readers (ROM_LAT=1 and ROM_LAT=3), each on its own ROM model that
//   shares one content table. A transaction-level model per reader predicts
//   every output each cycle; directed passes pin the model with hand-computed
//   latencies and word sequences, then a randomized phase exercises
//   start/ready/reset combinations.
//   Define ROM_READER_CHECKSUM_EN to build and check the checksum port.
// ----------------------------------------------------------------------------
module tb_rom_reader;
   import rom_reader_pkg::*;

   localparam int AW    = DEF_ADDR_W;
   localparam int DW    = DEF_DATA_W;
   localparam int DEPTH = 1 << AW;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   bit armed    = 1'b0;

   logic [DW-1:0] mem [DEPTH];

   rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();
   rom_reader_if #(.ADDR_W(AW), .DATA_W(DW)) if3 ();

   rom_reader #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut1 (
      .CLK (CLK),
      .RST (RST),
      .bus (if1)
   );

   rom_reader #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
      .CLK (CLK),
      .RST (RST),
      .bus (if3)
   );

   // Synchronous ROMs: registered address, data ROM_LAT clocks later.
   logic [DW-1:0] pipe1;
   logic [DW-1:0] pipe3 [3];
   always @(posedge CLK) begin
      pipe1    <= mem[if1.rom_addr];
      pipe3[0] <= mem[if3.rom_addr];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign if1.rom_data = pipe1;
   assign if3.rom_data = pipe3[2];

   // ---------------------------------------------------------------------
   // Behavioural model: a pass is "active" from start until the last word
   // is taken; each word becomes visible lat+1 clocks after its address is
   // issued and stays visible until the handshake.
   // ---------------------------------------------------------------------
   typedef struct packed {
      logic          active;
      logic          done;
      logic [2:0]    cnt;    // clocks until the current word is visible
      logic [AW-1:0] addr;
      logic [DW-1:0] word;
      logic [DW-1:0] chk;
   } model_t;

   function automatic model_t model_step(model_t m, logic rst, logic start,
                                         logic ready, int lat);
      model_t n = m;
      if (rst) begin
         n = '0;
      end else if (m.done) begin
         n.done = 1'b0;
      end else if (!m.active) begin
         if (start) begin
            n.active = 1'b1;
            n.addr   = '0;
            n.cnt    = 3'(lat + 1);
            n.chk    = '0;
         end
      end else if (m.cnt != 3'd0) begin
         n.cnt = m.cnt - 3'd1;
         if (n.cnt == 3'd0) n.word = mem[m.addr];
      end else if (ready) begin
         n.chk = m.chk ^ m.word;
         if (m.addr == AW'(DEPTH - 1)) begin
            n.active = 1'b0;
            n.done   = 1'b1;
         end else begin
            n.addr = m.addr + 1'b1;
            n.cnt  = 3'(lat + 1);
         end
      end
      return n;
   endfunction

   model_t m1, m3;
   always @(posedge CLK) begin
      m1 <= model_step(m1, RST, if1.start, if1.word_ready, 1);
      m3 <= model_step(m3, RST, if3.start, if3.word_ready, 3);
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge CLK) begin
      if (armed) begin
         check("d1 rom_addr",   32'(if1.rom_addr),   32'(m1.addr));
         check("d1 word_out",   32'(if1.word_out),   32'(m1.word));
         check("d1 word_valid", 32'(if1.word_valid), 32'(m1.active && m1.cnt == 3'd0));
         check("d1 busy",       32'(if1.busy),       32'(m1.active));
         check("d1 done",       32'(if1.done),       32'(m1.done));
         check("d3 rom_addr",   32'(if3.rom_addr),   32'(m3.addr));
         check("d3 word_out",   32'(if3.word_out),   32'(m3.word));
         check("d3 word_valid", 32'(if3.word_valid), 32'(m3.active && m3.cnt == 3'd0));
         check("d3 busy",       32'(if3.busy),       32'(m3.active));
         check("d3 done",       32'(if3.done),       32'(m3.done));
`ifdef ROM_READER_CHECKSUM_EN
         if (m1.done || !m1.active) check("d1 checksum", 32'(if1.checksum), 32'(m1.chk));
         if (m3.done || !m3.active) check("d3 checksum", 32'(if3.checksum), 32'(m3.chk));
`endif
      end
   end

   // Accepted-word and done-pulse monitors (inputs are stable at negedge).
   logic [DW-1:0] q1 [$];
   logic [DW-1:0] q3 [$];
   int done1 = 0;
   int done3 = 0;
   always @(negedge CLK) begin
      if (armed && !RST) begin
         if (if1.word_valid && if1.word_ready) q1.push_back(if1.word_out);
         if (if3.word_valid && if3.word_ready) q3.push_back(if3.word_out);
         if (if1.done) done1++;
         if (if3.done) done3++;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   function automatic logic valid_of(input int inst);
      return (inst == 1) ? if1.word_valid : if3.word_valid;
   endfunction

   function automatic logic done_of(input int inst);
      return (inst == 1) ? if1.done : if3.done;
   endfunction

   function automatic logic busy_of(input int inst);
      return (inst == 1) ? if1.busy : if3.busy;
   endfunction

   function automatic int qsize(input int inst);
      return (inst == 1) ? q1.size() : q3.size();
   endfunction

   function automatic int dcount(input int inst);
      return (inst == 1) ? done1 : done3;
   endfunction

   task automatic set_start(input int inst, input logic v);
      if (inst == 1) if1.start = v; else if3.start = v;
   endtask

   task automatic set_ready(input int inst, input logic v);
      if (inst == 1) if1.word_ready = v; else if3.word_ready = v;
   endtask

   task automatic pulse_start(input int inst);
      set_start(inst, 1'b1);
      tick();
      set_start(inst, 1'b0);
   endtask

   task automatic check_words(input string name, input int inst, input int base,
                              input logic [15:0] exp);
      logic [DW-1:0] w;
      check({name, " word count"}, 32'(qsize(inst) - base), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         if (base + i < qsize(inst)) begin
            w = (inst == 1) ? q1[base + i] : q3[base + i];
            check({name, " word"}, 32'(w), 32'(exp[15 - 4*i -: 4]));
         end
      end
   endtask

   task automatic wait_valid(input string name, input int inst);
      int n = 0;
      while (!valid_of(inst) && n < 40) begin
         tick();
         n++;
      end
      check({name, " word_valid seen"}, 32'(valid_of(inst)), 32'd1);
   endtask

   // Full pass with word_ready held high; first-valid and done clock counts
   // are measured from the edge that samples start.
   task automatic run_pass(input string name, input int inst, input logic [15:0] exp,
                           input int exp_first, input int exp_done,
                           input logic [DW-1:0] exp_chk);
      int base  = qsize(inst);
      int dbase = dcount(inst);
      int n     = 0;
      set_ready(inst, 1'b1);
      pulse_start(inst);
      while (!valid_of(inst) && n < 40) begin
         tick();
         n++;
      end
      check({name, " first valid clocks"}, 32'(n), 32'(exp_first));
      while (!done_of(inst) && n < 120) begin
         tick();
         n++;
      end
      check({name, " done clocks"}, 32'(n), 32'(exp_done));
      check({name, " busy low with done"}, 32'(busy_of(inst)), 32'd0);
`ifdef ROM_READER_CHECKSUM_EN
      check({name, " checksum"}, 32'((inst == 1) ? if1.checksum : if3.checksum), 32'(exp_chk));
`else
      if (exp_chk !== exp_chk) $display("unreachable");
`endif
      tick(3);
      check({name, " done pulses"}, 32'(dcount(inst) - dbase), 32'd1);
      check_words(name, inst, base, exp);
   endtask

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   initial begin
      int base;
      int dbase;
      int n;
      if1.start = 1'b0; if1.word_ready = 1'b0;
      if3.start = 1'b0; if3.word_ready = 1'b0;
      mem[0] = 4'h3; mem[1] = 4'h5; mem[2] = 4'hA; mem[3] = 4'hC;
      RST = 1'b1;
      tick(2);
      RST = 1'b0;
      armed = 1'b1;

      // Reset state
      check("reset rom_addr",   32'(if1.rom_addr),   32'd0);
      check("reset word_out",   32'(if1.word_out),   32'd0);
      check("reset word_valid", 32'(if1.word_valid), 32'd0);
      check("reset busy",       32'(if1.busy),       32'd0);
      check("reset done",       32'(if1.done),       32'd0);
      tick(2);

      // Full pass, ROM_LAT=1: valid after E2, last accept at E12.
      run_pass("pass lat1", 1, 16'h35AC, 2, 12, 4'h0);

      // Back-pressure on word 2 for 5 clocks.
      base = qsize(1);
      set_ready(1, 1'b0);
      pulse_start(1);
      for (int k = 0; k < DEPTH; k++) begin
         wait_valid("bp", 1);
         if (k == 2) begin
            repeat (5) begin
               tick();
               check("bp held word_out", 32'(if1.word_out), 32'h0000000A);
               check("bp held rom_addr", 32'(if1.rom_addr), 32'd2);
            end
         end
         set_ready(1, 1'b1);
         tick();
         set_ready(1, 1'b0);
      end
      n = 0;
      while (!done_of(1) && n < 20) begin
         tick();
         n++;
      end
      check("bp done seen", 32'(if1.done), 32'd1);
      tick(2);
      check_words("bp", 1, base, 16'h35AC);

      // Reset while holding the word at address 1.
      pulse_start(1);
      wait_valid("rst a0", 1);
      set_ready(1, 1'b1);
      tick();
      set_ready(1, 1'b0);
      wait_valid("rst a1", 1);
      check("rst pre rom_addr", 32'(if1.rom_addr), 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("rst rom_addr",   32'(if1.rom_addr),   32'd0);
      check("rst word_out",   32'(if1.word_out),   32'd0);
      check("rst word_valid", 32'(if1.word_valid), 32'd0);
      check("rst busy",       32'(if1.busy),       32'd0);
      check("rst done",       32'(if1.done),       32'd0);
      tick(4);
      check("rst not resumed", 32'(if1.busy), 32'd0);
      run_pass("after rst", 1, 16'h35AC, 2, 12, 4'h0);

      // start while busy and during DONE is ignored.
      base  = qsize(1);
      dbase = dcount(1);
      set_ready(1, 1'b1);
      pulse_start(1);
      tick(3);
      pulse_start(1);
      n = 0;
      while (!done_of(1) && n < 40) begin
         tick();
         n++;
      end
      check("ign done seen", 32'(if1.done), 32'd1);
      pulse_start(1);
      tick(10);
      check("ign single done", 32'(dcount(1) - dbase), 32'd1);
      check("ign idle after", 32'(if1.busy), 32'd0);
      check_words("ign", 1, base, 16'h35AC);

      // ROM_LAT=3: valid 4 clocks after start, 5 clocks per word.
      run_pass("pass lat3", 3, 16'h35AC, 4, 20, 4'h0);

      // Alternate contents; checksum 1^2^4^8 = F.
      mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h8;
      run_pass("pass 1248", 1, 16'h1248, 2, 12, 4'hF);
      run_pass("pass 1248 lat3", 3, 16'h1248, 4, 20, 4'hF);

      // Randomized phase against the model.
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      for (int c = 0; c < 800; c++) begin
         if1.start      = ($urandom_range(0, 7) == 0);
         if1.word_ready = $urandom_range(0, 1) == 1;
         if3.start      = ($urandom_range(0, 5) == 0);
         if3.word_ready = $urandom_range(0, 2) != 0;
         RST            = ($urandom_range(0, 149) == 0);
         tick();
      end
      RST = 1'b0;
      if1.start = 1'b0; if3.start = 1'b0;
      if1.word_ready = 1'b1; if3.word_ready = 1'b1;
      tick(30);
      check("final d1 idle", 32'(if1.busy), 32'd0);
      check("final d3 idle", 32'(if3.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
               checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/rom_reader.md
Name: rom_reader

Overview:
- Sequential read master for the synchronous lab ROM (registered address, data valid one or more clocks later).
- On a start pulse it walks every ROM address from 0 to 2**ADDR_W-1 and captures each returned word.
- Each word goes to a downstream consumer over a valid/ready handshake.
- It sits between the ROM and the game/lock control logic, which consumes the stored digit sequence.

Parameters:
- ADDR_W, 2, ROM address width; depth = 2**ADDR_W
- DATA_W, 4, ROM word width
- ROM_LAT, 1, clocks from the ROM sampling rom_addr to rom_data being valid; legal range 1..3

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  begin a full read pass; sampled only in IDLE
- rom_addr  out  ADDR_W  address driven to the ROM
- rom_data  in  DATA_W  ROM read data
- word_out  out  DATA_W  captured word; stable while word_valid=1
- word_valid  out  1  word_out holds a word not yet accepted
- word_ready  in  1  consumer accepts word_out when word_valid&&word_ready at a rising edge
- busy  out  1  high from the edge after start is accepted until DONE
- done  out  1  one-clock pulse after the last word is accepted

Behaviour:
- Interface rule: one clock, CLK; reset RST is synchronous and active-high.
- Reset: applies at any edge RST=1, including mid-pass.
  - Outputs after reset: state=IDLE, rom_addr=0, word_out=0, word_valid=0, busy=0, done=0, latency counter=0.
  - A partial pass is abandoned and not resumed.
- IDLE:
  - start=1 -> rom_addr<=0, lat_cnt<=0, busy<=1, go to WAIT.
  - start=0 -> stay in IDLE.
- WAIT:
  - lat_cnt increments each clock.
  - When lat_cnt==ROM_LAT -> go to CAPTURE.
  - rom_addr is held constant.
- CAPTURE: word_out<=rom_data, word_valid<=1, go to HOLD.
- HOLD: word_out and rom_addr are held.
  - On word_valid&&word_ready: word_valid<=0.
  - If rom_addr==2**ADDR_W-1 -> go to DONE.
  - Otherwise rom_addr<=rom_addr+1, lat_cnt<=0, go to WAIT.
- DONE: done=1 for exactly one clock, busy=0, then go to IDLE.
  - rom_addr stays at its last value until the next start.
- Address never wraps within a pass; the next pass restarts at 0.
- Timing, ROM_LAT=1, word_ready held high, start sampled at edge E0:
  - word_valid first high after E2.
  - Each word is valid for 1 clock; 3 clocks per word.
  - Last word accepted at E12; done high E12..E13; IDLE after E13.
  - General first-word latency: ROM_LAT+1 clocks after start.
- Back-pressure: word_ready=0 holds the HOLD state indefinitely with word_out unchanged and no further ROM address change.
- start while busy or in DONE is ignored; it is not queued.
- start and RST in the same cycle: RST wins.
- word_ready while word_valid=0 has no effect.

Optional Feature:
- Macro: ROM_READER_CHECKSUM_EN.
- When defined:
  - Extra output port checksum [DATA_W-1:0].
  - checksum is cleared to 0 when start is accepted and by RST.
  - It is XOR-accumulated with each word at the handshake edge.
  - It is valid and stable from the cycle done is high until the next accepted start.
- When undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Package rom_reader_pkg holds:
  - State encoding constants: IDLE=0, WAIT=1, CAPTURE=2, HOLD=3, DONE=4, 3-bit.
  - Default ADDR_W/DATA_W constants shared with the ROM and the bench.
- No sub-module is required; the FSM, latency counter and address counter live in one module.
- The checksum accumulator stays inline under the macro.

Test Plan (bench ROM model contents: 0:4'h3, 1:4'h5, 2:4'hA, 3:4'hC):
- Full pass with ROM_LAT=1 and word_ready=1 -> word_out sequence 3,5,A,C, one valid cycle each, 3 clocks apart; done pulses once after the 4th accept; busy falls with done.
- Back-pressure: word_ready=0 for 5 clocks on word 2 -> word_out stays 4'hA, rom_addr stays 2; the pass completes normally after word_ready rises.
- RST asserted while in HOLD on address 1 -> next cycle all outputs 0 and state IDLE; a new start reads 3,5,A,C from address 0.
- start pulsed while busy and again in the DONE cycle -> ignored; exactly one pass and one done pulse.
- ROM_LAT=3 with a matching 3-clock ROM model -> first word_valid 4 clocks after start; all words correct, with no stale-data capture.
- With ROM_READER_CHECKSUM_EN defined -> checksum = 3^5^A^C = 4'h0 at done; with contents 1,2,4,8 -> 4'hF.
